// File: rtl/sync_fifo_pkg.sv
// Shared sync_fifo defines and package: data-width default, length-width default
// and the burst reader state type.
`ifndef SYNC_FIFO_DEFINES_SVH
`define SYNC_FIFO_DEFINES_SVH
`define SYNC_FIFO_DATA_WIDTH 8
`endif

package sync_fifo_pkg;
  localparam int LEN_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN,
    DONE
  } burst_state_t;
endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready register slice; accepts a new word whenever it is empty
// or its current word leaves downstream in the same cycle.
`ifndef SYNC_FIFO_DATA_WIDTH
`define SYNC_FIFO_DATA_WIDTH 8
`endif

module stream_out_reg #(
  parameter int DATA_WIDTH = `SYNC_FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_fifo_burst_reader.sv
// Pops a requested number of words from a first-word-fall-through FIFO and
// streams them downstream, tracking word count, XOR checksum and early abort.
`ifndef SYNC_FIFO_DATA_WIDTH
`define SYNC_FIFO_DATA_WIDTH 8
`endif

module sync_fifo_burst_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = `SYNC_FIFO_DATA_WIDTH,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_burst_len,
  input  logic                  i_abort,
  input  logic                  i_fifo_valid,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_ready,
  output logic                  o_valid_m,
  output logic [DATA_WIDTH-1:0] o_data_m,
  input  logic                  i_ready_m,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted,
  output logic [LEN_WIDTH-1:0]  o_word_cnt,
  output logic [DATA_WIDTH-1:0] o_checksum
);

  burst_state_t          state, state_next;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  slot_free;
  logic                  pop;

  assign o_busy       = (state != IDLE);
  assign o_fifo_ready = (state == BURST) && (remaining != '0) && !i_abort && slot_free;
  assign pop          = o_fifo_ready && i_fifo_valid;

  stream_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (i_clk),
    .rst      (i_rst),
    .in_valid (pop),
    .in_data  (i_fifo_data),
    .in_ready (slot_free),
    .out_valid(o_valid_m),
    .out_data (o_data_m),
    .out_ready(i_ready_m)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next = (i_burst_len == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        if (i_abort) begin
          state_next = DRAIN;
        end else if (pop && (remaining == LEN_WIDTH'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!o_valid_m || i_ready_m) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Burst bookkeeping; results stay visible after DONE until the next accepted start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      remaining  <= '0;
      o_word_cnt <= '0;
      o_checksum <= '0;
      o_aborted  <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= (state == DONE);
      if ((state == IDLE) && i_start) begin
        remaining  <= i_burst_len;
        o_word_cnt <= '0;
        o_checksum <= '0;
        o_aborted  <= 1'b0;
      end else if (pop) begin
        remaining  <= remaining - LEN_WIDTH'(1);
        o_word_cnt <= o_word_cnt + LEN_WIDTH'(1);
        o_checksum <= o_checksum ^ i_fifo_data;
      end else if ((state == BURST) && i_abort) begin
        o_aborted <= 1'b1;
      end
    end
  end

endmodule
